// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: shifts bytes out MSB-first, one bit per clk_32f,
// with a comma preamble after reset/resync and comma fill whenever no data is offered.
module paralelo_serial_tx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       resync_in,
  output logic       ready_out,
  output logic       active_out,
  output logic       data_out
);

  localparam int unsigned        SYNC_W    = $clog2(COMMA_COUNT + 1);
  localparam logic [SYNC_W-1:0]  SYNC_ONE  = SYNC_W'(1);
  localparam logic [SYNC_W-1:0]  SYNC_FULL = SYNC_W'(COMMA_COUNT);
  localparam logic [2:0]         LAST_BIT  = 3'd7;

  logic [7:0]        shreg;
  logic [7:0]        shreg_nxt;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_nxt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [SYNC_W-1:0] sync_cnt_nxt;
  logic              resync_pend;
  logic              resync_pend_nxt;
  logic              boundary;

  assign boundary   = (bit_cnt == LAST_BIT);
  assign active_out = (sync_cnt == SYNC_FULL);
  assign ready_out  = active_out && boundary && !resync_pend && !resync_in;

  // State register; the reset preload already counts as preamble comma #1.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg       <= COMMA;
      bit_cnt     <= 3'd0;
      sync_cnt    <= SYNC_ONE;
      resync_pend <= 1'b0;
      data_out    <= 1'b0;
    end else begin
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      sync_cnt    <= sync_cnt_nxt;
      resync_pend <= resync_pend_nxt;
      data_out    <= shreg[7];
    end
  end

  // Next-state: shift within a byte, choose the next byte at the boundary.
  always_comb begin
    shreg_nxt       = {shreg[6:0], 1'b0};
    bit_cnt_nxt     = bit_cnt + 3'd1;
    sync_cnt_nxt    = sync_cnt;
    resync_pend_nxt = resync_pend;

    if (boundary) begin
      if (resync_pend || resync_in) begin
        shreg_nxt       = COMMA;
        sync_cnt_nxt    = SYNC_ONE;
        resync_pend_nxt = 1'b0;
      end else if (sync_cnt < SYNC_FULL) begin
        shreg_nxt    = COMMA;
        sync_cnt_nxt = sync_cnt + SYNC_ONE;
      end else if (valid_in && ready_out) begin
        shreg_nxt = data_in;
      end else begin
        shreg_nxt = COMMA;
      end
    end else if (resync_in) begin
      resync_pend_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: expected line bits are queued as stimulus
// is planned and popped one per edge; a second instance covers COMMA_COUNT == 1.
module tb_paralelo_serial_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       resync_in;
  logic       ready, active, dout;
  logic       ready1, active1, dout1;

  logic       rdy_s, rdy1_s, acc, acc1;
  int         edge_n;
  int         n_tests;
  int         n_fail;
  logic       exp_q[$];
  logic       exp1_q[$];

  paralelo_serial_tx #(.COMMA(8'hBC), .COMMA_COUNT(4)) dut (
    .clk_32f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .resync_in(resync_in), .ready_out(ready), .active_out(active), .data_out(dout)
  );

  paralelo_serial_tx #(.COMMA(8'hBC), .COMMA_COUNT(1)) dut1 (
    .clk_32f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .resync_in(resync_in), .ready_out(ready1), .active_out(active1), .data_out(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 7; i > 7 - n; i--) exp_q.push_back(v[i]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_bits(b, 8);
  endtask

  task automatic push_byte1(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) exp1_q.push_back(v[i]);
  endtask

  // One edge: sample ready mid-cycle, then check the line value just after the edge.
  task automatic tick();
    @(negedge clk);
    rdy_s  = ready;
    rdy1_s = ready1;
    @(posedge clk);
    acc  = rdy_s && valid_in;
    acc1 = rdy1_s && valid_in;
    #1;
    edge_n++;
    if (exp_q.size() > 0) check("data_out", 32'(dout), 32'(exp_q.pop_front()));
    if (exp1_q.size() > 0) check("data_out_cc1", 32'(dout1), 32'(exp1_q.pop_front()));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    resync_in = 1'b0;
    tick();
    check("rst_data_out", 32'(dout), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_active_cc1", 32'(active1), 32'(1));
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    int n_acc, n_rdy, first_acc, second_acc, resume;
    n_tests   = 0;
    n_fail    = 0;
    edge_n    = 0;
    reset     = 1'b1;
    data_in   = 8'h00;
    valid_in  = 1'b0;
    resync_in = 1'b0;

    // Idle after reset: six commas, preamble completes at edge 24, no transfers.
    do_reset();
    valid_in = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'hBC);
    n_acc = 0;
    for (int e = 0; e < 48; e++) begin
      tick();
      if (acc) n_acc++;
      if (edge_n == 23) check("t1_active_e23", 32'(active), 32'(0));
      if (edge_n == 24) check("t1_active_e24", 32'(active), 32'(1));
    end
    check("t1_no_xfer", 32'(n_acc), 32'(0));

    // Continuous valid: FF then EE, ready at 32 and 40 only.
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'hFF;
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_byte(8'hFF);
    push_byte(8'hEE);
    first_acc = 0; second_acc = 0; n_rdy = 0;
    for (int e = 0; e < 48; e++) begin
      tick();
      if (rdy_s && edge_n < 48) n_rdy++;
      if (acc) begin
        if (first_acc == 0) begin
          first_acc = edge_n;
          data_in   = 8'hEE;
        end else if (second_acc == 0) begin
          second_acc = edge_n;
        end
      end
    end
    check("t2_first_acc", 32'(first_acc), 32'(32));
    check("t2_second_acc", 32'(second_acc), 32'(40));
    check("t2_ready_pulses", 32'(n_rdy), 32'(2));

    // Valid dropped for one boundary: 00, idle comma, 5A.
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'h00;
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_byte(8'h00);
    push_byte(8'hBC);
    push_byte(8'h5A);
    for (int e = 0; e < 56; e++) begin
      tick();
      if (edge_n == 32) begin
        check("t3_acc_00", 32'(acc), 32'(1));
        valid_in = 1'b0;
      end
      if (edge_n == 40) begin
        check("t3_idle_ready", 32'(rdy_s), 32'(1));
        check("t3_idle_no_acc", 32'(acc), 32'(0));
        valid_in = 1'b1;
        data_in  = 8'h5A;
      end
      if (edge_n == 48) check("t3_acc_5a", 32'(acc), 32'(1));
    end

    // Resync mid-byte at edge 43 while streaming A5.
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_byte(8'hA5);
    push_byte(8'hA5);
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_byte(8'hA5);
    resume = 0;
    for (int e = 0; e < 88; e++) begin
      resync_in = (edge_n + 1 == 43);
      tick();
      if (edge_n == 48) check("t4_active_e48", 32'(active), 32'(0));
      if (edge_n == 72) check("t4_active_e72", 32'(active), 32'(1));
      if (acc && edge_n >= 48 && resume == 0) resume = edge_n;
    end
    resync_in = 1'b0;
    check("t4_resume_edge", 32'(resume), 32'(80));

    // Reset mid-byte at edge 36 abandons the byte and restarts the preamble.
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_bits(8'hA5, 3);
    for (int e = 0; e < 35; e++) tick();
    reset = 1'b1;
    tick();
    check("t5_rst_data_out", 32'(dout), 32'(0));
    check("t5_rst_active", 32'(active), 32'(0));
    reset  = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 4; i++) push_byte(8'hBC);
    push_byte(8'hA5);
    first_acc = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (acc && first_acc == 0) first_acc = edge_n;
    end
    check("t5_first_acc", 32'(first_acc), 32'(32));

    // COMMA_COUNT == 1: active from reset, first transfer at edge 8.
    do_reset();
    valid_in = 1'b1;
    data_in  = 8'h3C;
    push_byte1(8'hBC);
    push_byte1(8'h3C);
    first_acc = 0;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (acc1 && first_acc == 0) first_acc = edge_n;
    end
    check("t6_first_acc_cc1", 32'(first_acc), 32'(8));

    check("queues_drained", 32'(exp_q.size() + exp1_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
